// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: two requester ports (A = pipeline
// MEM stage, B = loader/debug), the shared data-memory port, the timeout
// flag and a debug view of the arbiter FSM state.
//
// Handshake: a requester raises <x>_req with we/addr/wdata stable and holds
// it until <x>_ack, which is a single-cycle pulse; <x>_rdata and err are
// meaningful only while that ack is high (rdata then holds until the port's
// next completion). On the memory side mem_req is held high with
// mem_we/addr/wdata stable until the cycle in which mem_ready is sampled
// high; mem_rdata is taken in that same cycle.
//
// Modport slave is the arbiter itself; modport master is its environment
// (requesters plus the data memory).
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
) ();

  // Requester port A
  logic              a_req;
  logic              a_we;
  logic [DATA_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_ack;

  // Requester port B
  logic              b_req;
  logic              b_we;
  logic [DATA_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_ack;

  // Completion status
  logic              err;

  // Data-memory port
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // FSM state for debug/checkers: 0 = IDLE, 1 = BUSY, 2 = RESP
  logic [1:0]        arb_state;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_rdata, a_ack,
    input  b_req, b_we, b_addr, b_wdata,
    output b_rdata, b_ack,
    output err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output arb_state
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_rdata, a_ack,
    output b_req, b_we, b_addr, b_wdata,
    input  b_rdata, b_ack,
    input  err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  arb_state
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Grants one of two requesters (A = pipeline
// MEM stage, B = loader/debug) access to a single data memory, holds the
// access until mem_ready or a wait-cycle timeout, then returns a one-cycle
// ack with load data and an error flag.
//
// FSM: IDLE -> BUSY (access in flight) -> RESP (ack cycle) -> IDLE.
// Best-case latency: request sampled at edge k, mem_ready high in cycle k+1,
// ack high in cycle k+2, next grant at edge k+3 at the earliest.
//
// Optional feature: define DMEM_ARB_RR_EN to replace fixed A-over-B priority
// with round-robin between simultaneous requests (the port not granted most
// recently wins; after reset A wins first). Without it B can starve while A
// keeps requesting.
module dmem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15   // max BUSY cycles waiting for mem_ready, 1..255
) (
  input  logic         CLK,
  input  logic         RST_N,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TIMEOUT);

  state_t            state;
  logic [7:0]        wait_cnt;   // BUSY cycles already elapsed
  logic              gnt_b;      // 1 = current access belongs to port B

  logic              any_req;
  logic              pick_b;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [7:0]        cnt_nxt;
  logic              tmo_hit;

`ifdef DMEM_ARB_RR_EN
  logic              last_b;     // 1 = B was granted most recently
`endif

  assign any_req = bus.a_req | bus.b_req;

  // Winner selection for the IDLE grant decision.
  always_comb begin
    pick_b = 1'b0;
`ifdef DMEM_ARB_RR_EN
    // Contention goes to whichever port was not granted last.
    if (bus.b_req && (!bus.a_req || !last_b)) begin
      pick_b = 1'b1;
    end
`else
    // Fixed priority: B only when A is not asking.
    if (bus.b_req && !bus.a_req) begin
      pick_b = 1'b1;
    end
`endif
  end

  // Steer the winner's request fields toward the memory-side registers.
  always_comb begin
    sel_we    = bus.a_we;
    sel_addr  = bus.a_addr;
    sel_wdata = bus.a_wdata;
    if (pick_b) begin
      sel_we    = bus.b_we;
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
    end
  end

  // Timeout fires at the edge where the elapsed-cycle count reaches TIMEOUT,
  // i.e. after exactly TIMEOUT cycles of mem_req without mem_ready.
  always_comb begin
    cnt_nxt = wait_cnt + 8'd1;
    tmo_hit = (cnt_nxt == TMO_C);
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      gnt_b         <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.a_rdata   <= '0;
      bus.b_rdata   <= '0;
      bus.a_ack     <= 1'b0;
      bus.b_ack     <= 1'b0;
      bus.err       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_b        <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_b         <= pick_b;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            wait_cnt      <= 8'd0;
            state         <= BUSY;
`ifdef DMEM_ARB_RR_EN
            last_b        <= pick_b;
`endif
          end
        end

        BUSY: begin
          // Request lines are ignored here: a dropped req does not abort.
          wait_cnt <= cnt_nxt;
          if (bus.mem_ready) begin
            // mem_ready wins over a simultaneous timeout.
            bus.mem_req <= 1'b0;
            bus.err     <= 1'b0;
            state       <= RESP;
            if (gnt_b) begin
              bus.b_rdata <= bus.mem_rdata;
              bus.b_ack   <= 1'b1;
            end else begin
              bus.a_rdata <= bus.mem_rdata;
              bus.a_ack   <= 1'b1;
            end
          end else if (tmo_hit) begin
            bus.mem_req <= 1'b0;
            bus.err     <= 1'b1;
            state       <= RESP;
            if (gnt_b) begin
              bus.b_rdata <= '0;
              bus.b_ack   <= 1'b1;
            end else begin
              bus.a_rdata <= '0;
              bus.a_ack   <= 1'b1;
            end
          end
        end

        RESP: begin
          // Ack and err live for exactly this cycle; no new grant here.
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          bus.err   <= 1'b0;
          wait_cnt  <= 8'd0;
          state     <= IDLE;
        end

        default: begin
          bus.mem_req <= 1'b0;
          bus.a_ack   <= 1'b0;
          bus.b_ack   <= 1'b0;
          bus.err     <= 1'b0;
          wait_cnt    <= 8'd0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Debug view of the FSM state.
  assign bus.arb_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Stimulus tasks push the expected
// completion {port_b, err, rdata} into exp_q; the ack monitor pops and
// compares whenever a_ack or b_ack is seen. Cycle-level timing (grant edge,
// mem_req duration, ack cycle) is checked inside the stimulus tasks.
module tb_dmem_arbiter;

  localparam int W   = 32;
  localparam int TMO = 15;

  logic CLK;
  logic RST_N;

  dmem_arbiter_if #(.DATA_W(W)) bus ();

  dmem_arbiter #(.DATA_W(W), .TIMEOUT(TMO)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];   // {port_b, err, rdata}
  logic [W+1:0] exp_e;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (bus.a_ack || bus.b_ack) begin
      check("ack_exclusive", W'(bus.a_ack & bus.b_ack), '0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b with no expected entry at %0t",
                 bus.a_ack, bus.b_ack, $time);
      end else begin
        exp_e = exp_q.pop_front();
        check("ack_port", W'(bus.b_ack), W'(exp_e[W+1]));
        check("ack_err", W'(bus.err), W'(exp_e[W]));
        check("ack_rdata", exp_e[W+1] ? bus.b_rdata : bus.a_rdata, exp_e[W-1:0]);
      end
    end else if (RST_N) begin
      check("err_idle", W'(bus.err), '0);
    end
  end

  // ---------------- driver tasks ----------------
  // One transaction on one port. ready_at = BUSY cycle index (0-based) in
  // which mem_ready is driven high; -1 means never. Entered and left #1
  // after a rising edge with the arbiter idle.
  task automatic run_txn(input bit port_b, input bit we, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata, input int ready_at,
                         input logic [W-1:0] rd, input bit drop_early);
    bit           to;
    int           req_cycles;
    int           ack_cycle;
    bit           ack_seen;
    int           exp_cycles;
    to = (ready_at < 0) || (ready_at >= TMO);
    exp_cycles = to ? TMO : ready_at + 1;
    exp_q.push_back({port_b, to, to ? W'(0) : rd});
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    tick();  // grant edge k
    req_cycles = 0;
    ack_cycle  = -1;
    ack_seen   = 1'b0;
    for (int c = 0; c < 40 && !ack_seen; c++) begin
      if (drop_early && c == 0) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
      bus.mem_ready = (c == ready_at);
      bus.mem_rdata = (c == ready_at) ? rd : (32'hBAD0_0000 | 32'(c));
      @(negedge CLK);
      if (bus.mem_req) begin
        req_cycles++;
        check("mem_addr", bus.mem_addr, addr);
        check("mem_wdata", bus.mem_wdata, wdata);
        check("mem_we", W'(bus.mem_we), W'(we));
      end
      if (bus.a_ack || bus.b_ack) begin
        ack_seen  = 1'b1;
        ack_cycle = c;
      end
      tick();
      bus.mem_ready = 1'b0;
    end
    // Now just past the edge that leaves RESP.
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    check("ack_seen", W'(ack_seen), W'(1));
    check("mem_req_cycles", W'(req_cycles), W'(exp_cycles));
    check("ack_cycle", W'(ack_cycle), W'(exp_cycles));
    @(negedge CLK);
    // req was still high at the RESP edge: it must not have been granted.
    check("no_regrant_resp", W'(bus.mem_req), '0);
    check("ack_one_cycle", W'(bus.a_ack | bus.b_ack), '0);
    tick();
  endtask

  // Both ports request continuously for four transactions.
  task automatic contention();
    bit exp_b;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h0000_0A00; bus.a_wdata = '0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h0000_0B00; bus.b_wdata = '0;
    for (int t = 0; t < 4; t++) begin
`ifdef DMEM_ARB_RR_EN
      exp_b = (t % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      tick();  // grant edge
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h1000 + 32'(t);
      exp_q.push_back({exp_b, 1'b0, 32'h1000 + 32'(t)});
      @(negedge CLK);
      check("rr_mem_req", W'(bus.mem_req), W'(1));
      check("grant_order", bus.mem_addr, exp_b ? 32'h0000_0B00 : 32'h0000_0A00);
      tick();  // -> RESP
      bus.mem_ready = 1'b0;
      tick();  // -> IDLE
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST_N = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    do_reset();

    // Reset state
    @(negedge CLK);
    check("rst_state", W'(bus.arb_state), '0);
    check("rst_mem_req", W'(bus.mem_req), '0);
    check("rst_mem_addr", bus.mem_addr, '0);
    check("rst_a_rdata", bus.a_rdata, '0);
    check("rst_b_rdata", bus.b_rdata, '0);
    check("rst_acks", W'({bus.a_ack, bus.b_ack}), '0);
    tick();

    // A load, fastest memory response
    run_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    // B store, memory never ready -> timeout
    run_txn(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, -1, 32'h0, 1'b0);
    @(negedge CLK);
    check("a_rdata_hold", bus.a_rdata, 32'hDEAD_BEEF);
    check("b_rdata_timeout", bus.b_rdata, '0);
    tick();
    // mem_ready in the last allowed cycle beats the timeout
    run_txn(1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, TMO - 1, 32'hCAFE_F00D, 1'b0);
    // B load with a few wait states
    run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3, 32'h0BAD_F00D, 1'b0);
    // Request withdrawn during BUSY still completes
    run_txn(1'b0, 1'b0, 32'h0000_0404, 32'h0, 2, 32'h7777_1111, 1'b1);
    @(negedge CLK);
    check("b_rdata_hold", bus.b_rdata, 32'h0BAD_F00D);
    tick();

    // Contention from a fresh reset
    do_reset();
    contention();

    // Reset in the middle of BUSY
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h0000_0500; bus.a_wdata = '0;
    tick();
    tick();
    tick();
    @(negedge CLK);
    check("midbusy_pre", W'(bus.mem_req), W'(1));
    tick();
    RST_N = 1'b0;
    bus.a_req = 1'b0;
    tick();
    @(negedge CLK);
    check("midbusy_mem_req", W'(bus.mem_req), '0);
    check("midbusy_state", W'(bus.arb_state), '0);
    check("midbusy_a_rdata", bus.a_rdata, '0);
    tick();
    RST_N = 1'b1;
    tick();
    run_txn(1'b0, 1'b0, 32'h0000_0600, 32'h0, 1, 32'h5555_AAAA, 1'b0);

    repeat (3) tick();
    check("queue_empty", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, address and data width of all ports.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum BUSY cycles to wait for mem_ready (1..255).
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port a_req  in  1  pipeline MEM-stage request; held until a_ack.
REQ-006 SHALL have port a_we  in  1  port A write enable (1 = store, 0 = load).
REQ-007 SHALL have port a_addr  in  DATA_W  port A byte address.
REQ-008 SHALL have port a_wdata  in  DATA_W  port A store data.
REQ-009 SHALL have port a_rdata  out  DATA_W  port A load data, valid while a_ack.
REQ-010 SHALL have port a_ack  out  1  port A completion, one-cycle pulse.
REQ-011 SHALL have ports b_req, b_we, b_addr, b_wdata, b_rdata, b_ack with port A widths and meanings, for the loader/debug requester.
REQ-012 SHALL have port err  out  1  timeout flag, valid only while a_ack or b_ack is high.
REQ-013 SHALL have port mem_req  out  1  data-memory access strobe.
REQ-014 SHALL have ports mem_we, mem_addr, mem_wdata  out  1/DATA_W/DATA_W  registered copy of the granted request.
REQ-015 SHALL have port mem_rdata  in  DATA_W  data-memory read data, sampled with mem_ready.
REQ-016 SHALL have port mem_ready  in  1  data-memory completion, sampled only in BUSY.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-018 IDLE: if any req at a rising edge, SHALL latch winner's we/addr/wdata onto mem_*, set mem_req=1, enter BUSY; else stay IDLE.
REQ-019 BUSY: mem_req and mem_we/addr/wdata SHALL stay stable; wait counter SHALL increment each cycle from 0.
REQ-020 BUSY with mem_ready=1 at an edge: SHALL capture mem_rdata into granted port's rdata, clear mem_req, enter RESP with err=0.
REQ-021 BUSY with counter reaching TIMEOUT and mem_ready=0: SHALL clear mem_req, load rdata with 0, enter RESP with err=1.
REQ-022 mem_ready and timeout in the same cycle: mem_ready SHALL win (err=0).
REQ-023 RESP: granted port's ack SHALL be 1 for exactly this one cycle; next state SHALL be IDLE; requests SHALL NOT be sampled in RESP.
REQ-024 Minimum latency: req sampled at edge k, mem_ready high in cycle k+1, ack high in cycle k+2; next grant no earlier than edge k+3.
REQ-025 req deassertion during BUSY SHALL NOT abort the transaction; it completes and acks.
REQ-026 rdata SHALL hold its value after ack until that port's next completion.
REQ-027 a_ack and b_ack SHALL never be high in the same cycle.
REQ-028 Default arbitration: fixed priority, A over B when both request in IDLE.

Reset
REQ-029 RST_N low at an edge SHALL force IDLE, counter 0, RR pointer to B, and all outputs (mem_*, a_*/b_* rdata and ack, err) to 0 regardless of state; an in-flight access is abandoned.

Configuration
REQ-030 With macro DMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the port not most recently granted wins, pointer updates on each grant, reset pointer makes A win first. Without it, REQ-028 applies and B may starve.

Verification
REQ-031 A load addr 0x100, mem_ready one cycle after mem_req with rdata 0xDEADBEEF -> a_ack in cycle k+2, a_rdata 0xDEADBEEF, err 0.
REQ-032 A and B request together, A held continuously -> fixed priority: B never granted; with DMEM_ARB_RR_EN: grants A,B,A,B.
REQ-033 B store addr 0x40 data 0x12345678, mem_ready never -> mem_req high 15 cycles, then b_ack with err 1, b_rdata 0.
REQ-034 mem_ready coincides with counter=TIMEOUT -> ack with err 0, rdata from mem_rdata.
REQ-035 RST_N low mid-BUSY -> next cycle mem_req 0, no ack; after release, a new A request completes normally.
